// File: rtl/rr_mux_arb_311.sv
// Round-robin arbiter driving a shared 4:1 single-bit mux.
// Owners keep the mux for at most MAX_HOLD grant cycles while someone else
// waits; handoffs happen on the release edge with no idle bubble.
//
// Handshake: req_311[k] is a level request; the block samples it only at
// arbitration edges, and the owner learns it holds the mux from gnt_311[k]
// (vld_311 high). Dropping req_311[owner] releases the mux on the next edge.
module rr_mux_arb_311 #(
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic       clk_311,
  input  logic       rst_n_311,
  input  logic [3:0] req_311,
  input  logic       i0_311,
  input  logic       i1_311,
  input  logic       i2_311,
  input  logic       i3_311,
  output logic [3:0] gnt_311,
  output logic       s1_311,
  output logic       s0_311,
  output logic       y_311,
  output logic       vld_311,
  output logic [7:0] nswitch_311,
  output logic       dbg_state_311
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  localparam logic [2:0] MAX_HC = 3'(MAX_HOLD);

  state_e     state_q, state_d;
  logic [1:0] owner_q, owner_d;
  logic [1:0] ptr_q, ptr_d;
  logic [2:0] hc_q, hc_d;
  logic [3:0] gnt_q, gnt_d;
  logic [7:0] nsw_q, nsw_d;

  logic [3:0] others;
  logic       release_now;
  logic [3:0] i_vec;

  // First set bit of req, searching start, start+1, ... mod 4.
  function automatic logic [1:0] rr_pick(input logic [1:0] start,
                                         input logic [3:0] req);
    logic [1:0] pick;
    logic [1:0] idx;
    pick = start;
    for (int k = 3; k >= 0; k--) begin
      idx = start + 2'(k);
      if (req[idx]) pick = idx;
    end
    return pick;
  endfunction

  // Next-state logic: arbitration, hold counting, release and handoff.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    ptr_d       = ptr_q;
    hc_d        = hc_q;
    nsw_d       = nsw_q;
    others      = req_311 & ~gnt_q;
    release_now = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req_311) begin
          state_d = GRANT;
          owner_d = rr_pick(ptr_q, req_311);
          hc_d    = 3'd1;
          nsw_d   = nsw_q + 8'd1;
        end
      end
      GRANT: begin
        release_now = !req_311[owner_q] || ((hc_q == MAX_HC) && (|others));
        if (release_now) begin
          ptr_d = owner_q + 2'd1;
          // The old owner is masked out: either its bit is low, or another
          // requester exists and must win.
          if (|others) begin
            owner_d = rr_pick(owner_q + 2'd1, others);
            hc_d    = 3'd1;
            nsw_d   = nsw_q + 8'd1;
          end else begin
            state_d = IDLE;
            owner_d = 2'd0;
            hc_d    = 3'd0;
          end
        end else if (hc_q != MAX_HC) begin
          hc_d = hc_q + 3'd1;
        end
      end
      default: begin
        state_d = IDLE;
        owner_d = 2'd0;
        hc_d    = 3'd0;
      end
    endcase
    gnt_d = (state_d == GRANT) ? (4'b0001 << owner_d) : 4'b0000;
  end

  // State, owner, pointer, hold counter, grant and switch counter flops.
  always_ff @(posedge clk_311 or negedge rst_n_311) begin
    if (!rst_n_311) begin
      state_q <= IDLE;
      owner_q <= 2'd0;
      ptr_q   <= 2'd0;
      hc_q    <= 3'd0;
      gnt_q   <= 4'b0000;
      nsw_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      hc_q    <= hc_d;
      gnt_q   <= gnt_d;
      nsw_q   <= nsw_d;
    end
  end

  assign i_vec          = {i3_311, i2_311, i1_311, i0_311};
  assign gnt_311        = gnt_q;
  assign s1_311         = owner_q[1];
  assign s0_311         = owner_q[0];
  assign vld_311        = (state_q == GRANT);
  assign y_311          = vld_311 & i_vec[owner_q];
  assign nswitch_311    = nsw_q;
  assign dbg_state_311  = state_q;

endmodule

// File: tb/tb_rr_mux_arb_311.sv
// Testbench for rr_mux_arb_311: hand-derived vector table, reference-model
// scoreboard for longer sequences, and directed reset / MAX_HOLD=1 cases.
module tb_rr_mux_arb_311;

  localparam int MAXH = 4;

  // Clock / reset
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = 4'b0000;
  logic [3:0] iv = 4'b0000;

  always #5 clk = ~clk;

  logic [3:0] gnt, gnt1;
  logic       s1, s0, y, vld, dbg;
  logic       s1_1, s0_1, y_1, vld_1, dbg_1;
  logic [7:0] nsw, nsw1;

  rr_mux_arb_311 #(.MAX_HOLD(MAXH)) dut (
    .clk_311(clk), .rst_n_311(rst_n), .req_311(req),
    .i0_311(iv[0]), .i1_311(iv[1]), .i2_311(iv[2]), .i3_311(iv[3]),
    .gnt_311(gnt), .s1_311(s1), .s0_311(s0), .y_311(y), .vld_311(vld),
    .nswitch_311(nsw), .dbg_state_311(dbg)
  );

  rr_mux_arb_311 #(.MAX_HOLD(1)) dut1 (
    .clk_311(clk), .rst_n_311(rst_n), .req_311(req),
    .i0_311(iv[0]), .i1_311(iv[1]), .i2_311(iv[2]), .i3_311(iv[3]),
    .gnt_311(gnt1), .s1_311(s1_1), .s0_311(s0_1), .y_311(y_1), .vld_311(vld_1),
    .nswitch_311(nsw1), .dbg_state_311(dbg_1)
  );

  // Scoreboard
  logic [15:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  function automatic logic [15:0] dut_out();
    return {gnt, s1, s0, vld, y, nsw};
  endfunction

  task automatic check(input string name, input logic [15:0] got,
                       input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic compare_pop(input string name);
    logic [15:0] e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: scoreboard empty, got %h expected entry", name, dut_out());
    end else begin
      e = exp_q.pop_front();
      check(name, dut_out(), e);
    end
  endtask

  // Reference model (MAX_HOLD = MAXH)
  bit         m_vld;
  logic [1:0] m_own, m_ptr;
  int         m_hc;
  logic [7:0] m_nsw;

  task automatic model_reset();
    m_vld = 0; m_own = 0; m_ptr = 0; m_hc = 0; m_nsw = 0;
  endtask

  function automatic logic [1:0] m_search(input logic [1:0] start,
                                          input logic [3:0] r);
    logic [1:0] idx;
    for (int k = 0; k < 4; k++) begin
      idx = start + 2'(k);
      if (r[idx]) return idx;
    end
    return start;
  endfunction

  task automatic model_step(input logic [3:0] r);
    logic [3:0] oth;
    if (!m_vld) begin
      if (r != 4'b0) begin
        m_own = m_search(m_ptr, r);
        m_vld = 1; m_hc = 1; m_nsw++;
      end
    end else begin
      oth = r;
      oth[m_own] = 1'b0;
      if (!r[m_own] || (m_hc == MAXH && oth != 4'b0)) begin
        m_ptr = m_own + 2'd1;
        if (oth != 4'b0) begin
          m_own = m_search(m_ptr, oth);
          m_hc = 1; m_nsw++;
        end else begin
          m_vld = 0; m_own = 0; m_hc = 0;
        end
      end else if (m_hc < MAXH) begin
        m_hc++;
      end
    end
  endtask

  function automatic logic [15:0] model_out(input logic [3:0] i_now);
    logic [3:0] g;
    g = m_vld ? (4'b0001 << m_own) : 4'b0000;
    return {g, (m_vld ? m_own : 2'b00), m_vld, (m_vld ? i_now[m_own] : 1'b0), m_nsw};
  endfunction

  // Driver tasks
  task automatic step(input logic [3:0] r, input logic [3:0] i_now, input string name);
    @(negedge clk);
    req = r; iv = i_now;
    model_step(r);
    exp_q.push_back(model_out(i_now));
    @(posedge clk);
    #1;
    compare_pop(name);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; req = 4'b0000;
    model_reset();
    #1;
    check("reset_state", dut_out(), 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Vector table
  typedef struct {
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] s;
    logic       vld;
    logic       y;
    logic [7:0] nsw;
  } vec_t;

  vec_t tbl[13];
  logic [3:0] g1_exp[4];

  initial begin
    // i0=1,i1=0,i2=1,i3=0 throughout the table.
    tbl[0]  = '{4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 8'd0};
    tbl[1]  = '{4'b0001, 4'b0001, 2'd0, 1'b1, 1'b1, 8'd1};
    tbl[2]  = '{4'b0001, 4'b0001, 2'd0, 1'b1, 1'b1, 8'd1};
    tbl[3]  = '{4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 8'd1};
    tbl[4]  = '{4'b0100, 4'b0100, 2'd2, 1'b1, 1'b1, 8'd2};
    tbl[5]  = '{4'b0100, 4'b0100, 2'd2, 1'b1, 1'b1, 8'd2};
    tbl[6]  = '{4'b1000, 4'b1000, 2'd3, 1'b1, 1'b0, 8'd3};
    tbl[7]  = '{4'b1001, 4'b1000, 2'd3, 1'b1, 1'b0, 8'd3};
    tbl[8]  = '{4'b1001, 4'b1000, 2'd3, 1'b1, 1'b0, 8'd3};
    tbl[9]  = '{4'b1001, 4'b1000, 2'd3, 1'b1, 1'b0, 8'd3};
    tbl[10] = '{4'b1001, 4'b0001, 2'd0, 1'b1, 1'b1, 8'd4};
    tbl[11] = '{4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 8'd4};
    tbl[12] = '{4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0, 8'd5};
    g1_exp[0] = 4'b0001; g1_exp[1] = 4'b0010;
    g1_exp[2] = 4'b0001; g1_exp[3] = 4'b0010;

    model_reset();
    do_reset();

    // Table-driven vectors
    for (int n = 0; n < 13; n++) begin
      @(negedge clk);
      req = tbl[n].req; iv = 4'b0101;
      exp_q.push_back({tbl[n].gnt, tbl[n].s, tbl[n].vld, tbl[n].y, tbl[n].nsw});
      @(posedge clk);
      #1;
      compare_pop($sformatf("tbl%0d", n));
    end

    // Single requester for 10 cycles then drop
    do_reset();
    for (int n = 0; n < 10; n++) step(4'b0001, 4'b0101, "single");
    step(4'b0000, 4'b0101, "single_idle");
    check("single_nsw", {8'd0, nsw}, 16'd1);

    // Full contention round robin
    do_reset();
    for (int n = 0; n < 22; n++) step(4'b1111, 4'b0101, "rr_all");

    // Uncontended saturation
    do_reset();
    for (int n = 0; n < 20; n++) step(4'b0010, 4'b0101, "sat");
    check("sat_nsw", {gnt, 4'b0000, nsw}, {4'b0010, 4'b0000, 8'd1});

    // Reset mid-GRANT of owner 1, then req=1010 grants owner 1 first
    do_reset();
    step(4'b0010, 4'b0001, "pre_rst");
    step(4'b0010, 4'b0001, "pre_rst");
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("async_rst", dut_out(), 16'h0000);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(4'b1010, 4'b0001, "post_rst");
    check("post_rst_owner", {12'd0, gnt}, 16'h0002);

    // MAX_HOLD = 1 instance alternates every cycle
    do_reset();
    for (int n = 0; n < 4; n++) begin
      step(4'b0011, 4'b0101, "mh4_pair");
      check($sformatf("mh1_gnt%0d", n), {12'd0, gnt1}, {12'd0, g1_exp[n]});
    end

    // Random traffic
    do_reset();
    for (int n = 0; n < 300; n++)
      step(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), "rand");

    // Counter wrap after 256 grant events
    do_reset();
    for (int n = 0; n < 256; n++) begin
      step(4'b0001, 4'b0000, "wrap");
      step(4'b0000, 4'b0000, "wrap");
    end
    check("wrap_nsw", {8'd0, nsw}, 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
